call_ret_unit: RTL and testbench

CALL_RET_UNIT -- requirements
Module: call_ret_unit

---
 rtl/call_ret_unit_pkg.sv | 22 ++
 rtl/call_ret_unit.sv | 147 ++++++++++++++
 tb/tb_call_ret_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/call_ret_unit_pkg.sv
// -----------------------------------------------------------------------------
// call_ret_unit_pkg
// Shared processor definitions used by the CALL/RET sequencer:
//   state_e  - sequencer FSM state encoding
//   STK_PUSH - stk_rw value for a push (post-increment of the stack pointer)
//   STK_POP  - stk_rw value for a pop  (pre-decrement of the stack pointer)
// -----------------------------------------------------------------------------
package call_ret_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH    = 3'd1,
    ST_CALL_LD = 3'd2,
    ST_POP     = 3'd3,
    ST_RD      = 3'd4,
    ST_RET_LD  = 3'd5
  } state_e;

  localparam logic STK_PUSH = 1'b0;
  localparam logic STK_POP  = 1'b1;

endpackage

// File: rtl/call_ret_unit.sv
// -----------------------------------------------------------------------------
// call_ret_unit
// Sequences subroutine CALL and RET against an external stack pointer block
// and a synchronous stack RAM (1-cycle read latency).
//   CALL: IDLE -> PUSH (write pc+1 at stk_addr, bump pointer) -> CALL_LD
//         (load target).  pc_load arrives 2 cycles after acceptance.
//   RET : IDLE -> POP (drop pointer) -> RD (address RAM at new pointer)
//         -> RET_LD (load RAM data).  pc_load arrives 3 cycles after acceptance.
// A CALL at full depth pulses ovf_err; a RET at zero depth pulses udf_err.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   call_req, ret_req   - requests, sampled only in IDLE (CALL wins)
//   pc, target          - current CALL address and CALL destination
//   stk_addr            - stack pointer (next free slot) from the stack block
//   stk_en, stk_rw      - stack pointer strobe and direction
//   mem_we, mem_addr,
//   mem_wdata, mem_rdata- stack RAM interface
//   pc_load, pc_next    - PC load strobe and value
//   busy                - FSM not in IDLE
//   ovf_err, udf_err    - one-cycle rejection pulses
// -----------------------------------------------------------------------------
module call_ret_unit
  import call_ret_unit_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stk_addr,
  output logic          stk_en,
  output logic          stk_rw,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata,
  output logic          pc_load,
  output logic [AW-1:0] pc_next,
  output logic          busy,
  output logic          ovf_err,
  output logic          udf_err
);

  localparam int            DW        = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  state_e        state_q;
  logic [DW-1:0] depth_q;
  logic [AW-1:0] target_q;
  logic          stk_en_q, stk_rw_q, mem_we_q, pc_load_q, ovf_q, udf_q;
  logic [AW-1:0] mem_wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      target_q    <= '0;
      stk_en_q    <= 1'b0;
      stk_rw_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      pc_load_q   <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless re-asserted below.
      stk_en_q    <= 1'b0;
      stk_rw_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      pc_load_q   <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (call_req) begin
            if (depth_q == DEPTH_MAX) begin
              ovf_q <= 1'b1;
            end else begin
              state_q     <= ST_PUSH;
              depth_q     <= depth_q + DW'(1);
              target_q    <= target;
              stk_en_q    <= 1'b1;
              stk_rw_q    <= STK_PUSH;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= pc + AW'(1);
            end
          end else if (ret_req) begin
            if (depth_q == '0) begin
              udf_q <= 1'b1;
            end else begin
              state_q  <= ST_POP;
              depth_q  <= depth_q - DW'(1);
              stk_en_q <= 1'b1;
              stk_rw_q <= STK_POP;
            end
          end
        end
        ST_PUSH: begin
          state_q   <= ST_CALL_LD;
          pc_load_q <= 1'b1;
        end
        ST_CALL_LD: state_q <= ST_IDLE;
        ST_POP:     state_q <= ST_RD;
        ST_RD: begin
          state_q   <= ST_RET_LD;
          pc_load_q <= 1'b1;
        end
        ST_RET_LD: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // The RAM address must track the live stack pointer: in RD it is the value
  // after the POP decrement, which only exists after the POP edge.
  assign mem_addr = (state_q == ST_PUSH || state_q == ST_RD) ? stk_addr : '0;

  // RAM read data is only valid in RET_LD, so it is forwarded rather than
  // registered to keep RET latency at 3 cycles.
  always_comb begin
    pc_next = '0;
    case (state_q)
      ST_CALL_LD: pc_next = target_q;
      ST_RET_LD:  pc_next = mem_rdata;
      default:    pc_next = '0;
    endcase
  end

  assign stk_en    = stk_en_q;
  assign stk_rw    = stk_rw_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_load   = pc_load_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_call_ret_unit.sv
// -----------------------------------------------------------------------------
// tb_call_ret_unit
// Bench for call_ret_unit (AW=8, DEPTH=4) with a behavioural stack pointer
// block and a synchronous stack RAM around it.
// -----------------------------------------------------------------------------
module tb_call_ret_unit;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {K_CALL, K_RET, K_OVF, K_UDF} kind_e;

  typedef struct {
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    kind_e         kind;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_wdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          call_req, ret_req;
  logic [AW-1:0] pc, target, stk_addr, mem_addr, mem_wdata, mem_rdata, pc_next;
  logic          stk_en, stk_rw, mem_we, pc_load, busy, ovf_err, udf_err;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] sb[$];
  vec_t vecs[13];

  call_ret_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .call_req  (call_req),
    .ret_req   (ret_req),
    .pc        (pc),
    .target    (target),
    .stk_addr  (stk_addr),
    .stk_en    (stk_en),
    .stk_rw    (stk_rw),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  always #5 clk = ~clk;

  // Stack pointer block and stack RAM environment.
  logic [AW-1:0] ram [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_addr <= '0;
    end else if (stk_en) begin
      stk_addr <= stk_rw ? stk_addr - 8'd1 : stk_addr + 8'd1;
    end
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for pc_load, which must come one cycle after the last
  // sampled cycle, and compares pc_next against the scoreboard head.
  task automatic expect_load(input string tag);
    int   waited = 0;
    logic got    = 1'b0;
    while (!got && waited < 6) begin
      step();
      waited++;
      if (pc_load) got = 1'b1;
    end
    check({tag, " load seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " load latency"}, waited, 32'd1);
      if (sb.size() == 0) check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      else                check({tag, " pc_next"}, pc_next, sb.pop_front());
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    call_req = v.call;
    ret_req  = v.ret;
    pc       = v.pc;
    target   = v.target;
    if (v.kind == K_CALL || v.kind == K_RET) sb.push_back(v.exp_pc);
    step();
    call_req = 1'b0;
    ret_req  = 1'b0;
    case (v.kind)
      K_CALL: begin
        check({tag, " push strobes"}, {stk_en, stk_rw, mem_we, pc_load, busy}, 5'b10101);
        check({tag, " push addr"}, mem_addr, v.exp_addr);
        check({tag, " push data"}, mem_wdata, v.exp_wdata);
        expect_load(tag);
      end
      K_RET: begin
        check({tag, " pop strobes"}, {stk_en, stk_rw, mem_we, pc_load, busy}, 5'b11001);
        step();
        check({tag, " rd strobes"}, {stk_en, mem_we, pc_load, busy}, 4'b0001);
        check({tag, " rd addr"}, mem_addr, v.exp_addr);
        expect_load(tag);
      end
      default: begin
        check({tag, " err pulse"}, {ovf_err, udf_err, stk_en, mem_we, pc_load, busy},
              {v.kind == K_OVF, v.kind == K_UDF, 4'b0000});
      end
    endcase
    step();
    check({tag, " back to idle"}, {ovf_err, udf_err, pc_load, stk_en, busy}, 5'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //           call  ret   pc     target kind    exp_pc exp_addr exp_wdata
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, K_UDF,  8'h00, 8'h00, 8'h00};  // RET at reset
    vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h40, K_CALL, 8'h40, 8'h00, 8'h11};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, K_RET,  8'h11, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h20, 8'h50, K_CALL, 8'h50, 8'h00, 8'h21};
    vecs[4]  = '{1'b1, 1'b1, 8'h30, 8'h60, K_CALL, 8'h60, 8'h01, 8'h31};  // CALL wins
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 8'h70, K_CALL, 8'h70, 8'h02, 8'h00};  // pc+1 wraps
    vecs[6]  = '{1'b1, 1'b0, 8'h40, 8'h80, K_CALL, 8'h80, 8'h03, 8'h41};  // now full
    vecs[7]  = '{1'b1, 1'b0, 8'h50, 8'h90, K_OVF,  8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, K_RET,  8'h41, 8'h03, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, K_RET,  8'h00, 8'h02, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, K_RET,  8'h31, 8'h01, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h00, K_RET,  8'h21, 8'h00, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 8'h00, K_UDF,  8'h00, 8'h00, 8'h00};

    rst = 1'b1; call_req = 1'b0; ret_req = 1'b0; pc = '0; target = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", {stk_en, stk_rw, mem_we, pc_load, busy, ovf_err, udf_err}, 7'b0);
    check("reset buses", {mem_addr, mem_wdata, pc_next}, 24'h0);
    rst = 1'b0;
    step();

    // Table: requests issued back to back, each in the first IDLE cycle.
    for (int i = 0; i < 13; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Requests raised while busy must be ignored.
    call_req = 1'b1; pc = 8'h60; target = 8'h70;
    sb.push_back(8'h70);
    step();
    check("busy call push data", mem_wdata, 8'h61);
    check("busy call push addr", mem_addr, 8'h00);
    call_req = 1'b1; ret_req = 1'b1; target = 8'hAA;
    step();
    check("busy call load", 32'(pc_load), 32'd1);
    check("busy call pc_next", pc_next, (sb.size() != 0) ? sb.pop_front() : 8'hFF);
    call_req = 1'b0; ret_req = 1'b0;
    step();
    check("busy noise dropped", {busy, stk_en, mem_we}, 3'b0);
    run_req('{1'b1, 1'b0, 8'h61, 8'h72, K_CALL, 8'h72, 8'h01, 8'h62}, "second call");

    // Reset during RD abandons the RET.
    ret_req = 1'b1;
    step();
    ret_req = 1'b0;
    check("abort pop strobes", {stk_en, stk_rw, busy}, 3'b111);
    step();
    check("abort rd addr", mem_addr, 8'h01);
    rst = 1'b1;
    #1;
    check("abort async outputs", {stk_en, stk_rw, mem_we, pc_load, busy, ovf_err, udf_err}, 7'b0);
    check("abort async buses", {mem_addr, mem_wdata, pc_next}, 24'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    run_req('{1'b0, 1'b1, 8'h00, 8'h00, K_UDF, 8'h00, 8'h00, 8'h00}, "ret after reset");

    check("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
